// File: rtl/uart_stream_router.sv
// UART byte-stream router: escape-selected RX steering, round-robin TX merge, echo loop.
// Define TX_LINE_LOCK_EN to hold TX arbitration on one channel until it sends a line feed.
module uart_stream_router #(
    parameter int                    N_CH       = 4,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] ESC_CODE   = DATA_WIDTH'(8'h1B)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         echo,
    input  logic [DATA_WIDTH-1:0]        rdata,
    input  logic                         rvalid,
    output logic                         rready,
    output logic [DATA_WIDTH-1:0]        wdata,
    output logic                         wvalid,
    input  logic                         wready,
    output logic [N_CH*DATA_WIDTH-1:0]   ch_rdata,
    output logic [N_CH-1:0]              ch_rvalid,
    input  logic [N_CH-1:0]              ch_rready,
    input  logic [N_CH*DATA_WIDTH-1:0]   ch_wdata,
    input  logic [N_CH-1:0]              ch_wvalid,
    output logic [N_CH-1:0]              ch_wready,
    output logic [$clog2(N_CH)-1:0]      sel,
    output logic                         esc_err
);

    localparam int SW = $clog2(N_CH);

    typedef enum logic {S_PASS, S_ESC} rx_state_e;

    function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] a, input int b);
        return SW'((int'(a) + b) % N_CH);
    endfunction

    rx_state_e             state_q, state_d;
    logic [SW-1:0]         sel_q, sel_d;
    logic                  esc_err_q, esc_err_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic [SW-1:0]         rx_tag_q, rx_tag_d;
    logic                  rx_echo_q, rx_echo_d;
    logic                  rx_full_q, rx_full_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  tx_full_q, tx_full_d;
    logic [SW-1:0]         ptr_q, ptr_d;

    logic                  tx_drain, tx_free, echo_xfer, rx_drain, pop;
    logic                  rx_load, rx_load_echo;
    logic                  arb_en, found, grant;
    logic [SW-1:0]         gnt_idx;
    logic [DATA_WIDTH-1:0] gnt_data;

`ifdef TX_LINE_LOCK_EN
    logic                  lock_q, lock_d;
    logic [SW-1:0]         lock_ch_q, lock_ch_d;
`endif

    assign tx_drain  = tx_full_q & wready;
    assign tx_free   = ~tx_full_q | tx_drain;
    assign echo_xfer = rx_full_q & rx_echo_q & tx_free;
    assign rx_drain  = rx_full_q & (rx_echo_q ? tx_free : ch_rready[rx_tag_q]);
    // Gated by rst so nothing is popped or granted while reset is held.
    assign rready    = rst & (~rx_full_q | rx_drain);
    assign pop       = rvalid & rready;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        esc_err_d    = 1'b0;
        rx_load      = 1'b0;
        rx_load_echo = 1'b0;
        if (pop) begin
            if (echo) begin
                rx_load      = 1'b1;
                rx_load_echo = 1'b1;
            end else begin
                case (state_q)
                    S_PASS: begin
                        if (rdata == ESC_CODE) state_d = S_ESC;
                        else                   rx_load = 1'b1;
                    end
                    default: begin
                        state_d = S_PASS;
                        if (rdata == ESC_CODE)
                            rx_load = 1'b1;
                        else if (rdata < DATA_WIDTH'(N_CH))
                            sel_d = rdata[SW-1:0];
                        else
                            esc_err_d = 1'b1;
                    end
                endcase
            end
        end
    end

    always_comb begin
        rx_full_d = rx_full_q;
        rx_data_d = rx_data_q;
        rx_tag_d  = rx_tag_q;
        rx_echo_d = rx_echo_q;
        if (rx_load) begin
            rx_full_d = 1'b1;
            rx_data_d = rdata;
            rx_tag_d  = sel_q;
            rx_echo_d = rx_load_echo;
        end else if (rx_drain) begin
            rx_full_d = 1'b0;
        end
    end

    assign arb_en = rst & tx_free & ~echo & ~(rx_full_q & rx_echo_q);

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
`ifdef TX_LINE_LOCK_EN
        if (lock_q) begin
            found   = ch_wvalid[lock_ch_q];
            gnt_idx = lock_ch_q;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (!found && ch_wvalid[wrap_add(ptr_q, i)]) begin
                    found   = 1'b1;
                    gnt_idx = wrap_add(ptr_q, i);
                end
            end
        end
`else
        for (int i = 0; i < N_CH; i++) begin
            if (!found && ch_wvalid[wrap_add(ptr_q, i)]) begin
                found   = 1'b1;
                gnt_idx = wrap_add(ptr_q, i);
            end
        end
`endif
    end

    assign grant    = arb_en & found;
    assign gnt_data = ch_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        ch_wready = '0;
        if (grant) ch_wready[gnt_idx] = 1'b1;
    end

    always_comb begin
        ptr_d = ptr_q;
`ifdef TX_LINE_LOCK_EN
        lock_d    = lock_q;
        lock_ch_d = lock_ch_q;
        if (grant) begin
            if (gnt_data == DATA_WIDTH'('h0A)) begin
                lock_d = 1'b0;
                ptr_d  = wrap_add(gnt_idx, 1);
            end else begin
                lock_d    = 1'b1;
                lock_ch_d = gnt_idx;
            end
        end
`else
        if (grant) ptr_d = wrap_add(gnt_idx, 1);
`endif
    end

    always_comb begin
        tx_full_d = tx_full_q;
        tx_data_d = tx_data_q;
        if (echo_xfer) begin
            tx_full_d = 1'b1;
            tx_data_d = rx_data_q;
        end else if (grant) begin
            tx_full_d = 1'b1;
            tx_data_d = gnt_data;
        end else if (tx_drain) begin
            tx_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_PASS;
            sel_q     <= '0;
            esc_err_q <= 1'b0;
            rx_full_q <= 1'b0;
            rx_data_q <= '0;
            rx_tag_q  <= '0;
            rx_echo_q <= 1'b0;
            tx_full_q <= 1'b0;
            tx_data_q <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            esc_err_q <= esc_err_d;
            rx_full_q <= rx_full_d;
            rx_data_q <= rx_data_d;
            rx_tag_q  <= rx_tag_d;
            rx_echo_q <= rx_echo_d;
            tx_full_q <= tx_full_d;
            tx_data_q <= tx_data_d;
            ptr_q     <= ptr_d;
        end
    end

`ifdef TX_LINE_LOCK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_ch_q <= lock_ch_d;
        end
    end
`endif

    always_comb begin
        for (int k = 0; k < N_CH; k++)
            ch_rvalid[k] = rx_full_q & ~rx_echo_q & (rx_tag_q == SW'(k));
    end

    assign ch_rdata = {N_CH{rx_data_q}};
    assign wvalid   = tx_full_q;
    assign wdata    = tx_data_q;
    assign sel      = sel_q;
    assign esc_err  = esc_err_q;

endmodule

// File: tb/tb_uart_stream_router.sv
// Directed bench for uart_stream_router (N_CH=4, 8-bit bytes).
// Build with TX_LINE_LOCK_EN defined to include the line-lock sequence.
module tb_uart_stream_router;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        echo = 1'b0;
    logic [7:0]  rdata = '0;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [7:0]  wdata;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [31:0] ch_rdata;
    logic [3:0]  ch_rvalid;
    logic [3:0]  ch_rready = '0;
    logic [31:0] ch_wdata = '0;
    logic [3:0]  ch_wvalid = '0;
    logic [3:0]  ch_wready;
    logic [1:0]  sel;
    logic        esc_err;

    int checks = 0;
    int failures = 0;

    uart_stream_router #(.N_CH(4), .DATA_WIDTH(8), .ESC_CODE(8'h1B)) dut (
        .clk(clk), .rst(rst), .echo(echo),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .ch_rdata(ch_rdata), .ch_rvalid(ch_rvalid), .ch_rready(ch_rready),
        .ch_wdata(ch_wdata), .ch_wvalid(ch_wvalid), .ch_wready(ch_wready),
        .sel(sel), .esc_err(esc_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        echo = 1'b0; rvalid = 1'b0; rdata = '0;
        ch_rready = '0; ch_wvalid = '0; ch_wdata = '0; wready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    typedef struct {
        logic [7:0] rd;
        logic       rv;
        logic [3:0] crr;
        logic       e_rready;
        logic [3:0] e_rvalid;
        logic [7:0] e_rdata;
        logic [1:0] e_sel;
        logic       e_err;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] rd, input logic rv, input logic [3:0] crr,
                                input logic er, input logic [3:0] ev, input logic [7:0] ed,
                                input logic [1:0] es, input logic ee);
        vec_t v;
        v.rd = rd; v.rv = rv; v.crr = crr;
        v.e_rready = er; v.e_rvalid = ev; v.e_rdata = ed;
        v.e_sel = es; v.e_err = ee;
        return v;
    endfunction

    function automatic logic [7:0] rr_byte(input logic [3:0] g);
        case (g)
            4'b0001: return 8'hA0;
            4'b0010: return 8'hA1;
            4'b0100: return 8'hA2;
            default: return 8'hA3;
        endcase
    endfunction

    vec_t       vt[14];
    logic [3:0] rr_exp[7];
    logic [7:0] q[$];
    logic [7:0] bp_exp[6];
    logic [7:0] ec_exp[3];
    int         grants;

    initial begin
        // Reset state while rst is held low
        #12;
        chk("rst_wvalid", 32'(wvalid), 0);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_ch_rvalid", 32'(ch_rvalid), 0);
        chk("rst_rready", 32'(rready), 0);
        chk("rst_esc_err", 32'(esc_err), 0);
        chk("rst_ch_wready", 32'(ch_wready), 0);
        reset_dut();

        // RX steering: 41, 1B 02 (sel=2), 55, 1B 1B literal, 1B 07 invalid, 1B 03
        vt[0]  = mk(8'h41, 1, 4'hF, 1, 4'b0000, 8'h00, 2'd0, 0);
        vt[1]  = mk(8'h1B, 1, 4'hF, 1, 4'b0001, 8'h41, 2'd0, 0);
        vt[2]  = mk(8'h02, 1, 4'hF, 1, 4'b0000, 8'h00, 2'd0, 0);
        vt[3]  = mk(8'h55, 1, 4'hF, 1, 4'b0000, 8'h00, 2'd2, 0);
        vt[4]  = mk(8'h1B, 1, 4'h0, 0, 4'b0100, 8'h55, 2'd2, 0);
        vt[5]  = mk(8'h1B, 1, 4'h4, 1, 4'b0100, 8'h55, 2'd2, 0);
        vt[6]  = mk(8'h1B, 1, 4'hF, 1, 4'b0000, 8'h00, 2'd2, 0);
        vt[7]  = mk(8'h1B, 1, 4'hF, 1, 4'b0100, 8'h1B, 2'd2, 0);
        vt[8]  = mk(8'h07, 1, 4'hF, 1, 4'b0000, 8'h00, 2'd2, 0);
        vt[9]  = mk(8'h00, 0, 4'hF, 1, 4'b0000, 8'h00, 2'd2, 1);
        vt[10] = mk(8'h00, 0, 4'hF, 1, 4'b0000, 8'h00, 2'd2, 0);
        vt[11] = mk(8'h1B, 1, 4'hF, 1, 4'b0000, 8'h00, 2'd2, 0);
        vt[12] = mk(8'h03, 1, 4'hF, 1, 4'b0000, 8'h00, 2'd2, 0);
        vt[13] = mk(8'h00, 0, 4'hF, 1, 4'b0000, 8'h00, 2'd3, 0);
        for (int i = 0; i < 14; i++) begin
            rdata = vt[i].rd; rvalid = vt[i].rv; ch_rready = vt[i].crr;
            #1;
            chk($sformatf("v%0d_rready", i), 32'(rready), 32'(vt[i].e_rready));
            chk($sformatf("v%0d_ch_rvalid", i), 32'(ch_rvalid), 32'(vt[i].e_rvalid));
            chk($sformatf("v%0d_sel", i), 32'(sel), 32'(vt[i].e_sel));
            chk($sformatf("v%0d_esc_err", i), 32'(esc_err), 32'(vt[i].e_err));
            chk($sformatf("v%0d_wvalid", i), 32'(wvalid), 0);
            if (vt[i].e_rvalid != 4'b0000)
                chk($sformatf("v%0d_ch_rdata", i), 32'(ch_rdata[7:0]), 32'(vt[i].e_rdata));
            cyc();
        end
        rvalid = 1'b0;

        // Round robin with channel 2 idle
        reset_dut();
        rr_exp = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0001};
        ch_wdata = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        ch_wvalid = 4'b1011;
        wready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            #1;
            chk($sformatf("rr%0d_ch_wready", i), 32'(ch_wready), 32'(rr_exp[i]));
            chk($sformatf("rr%0d_wvalid", i), 32'(wvalid), (i == 0) ? 0 : 1);
            if (i > 0)
                chk($sformatf("rr%0d_wdata", i), 32'(wdata), 32'(rr_byte(rr_exp[i-1])));
            cyc();
        end
        ch_wvalid = '0;

        // Backpressure: one capture while stalled, then no loss or duplication
        reset_dut();
        ch_wdata = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
        ch_wvalid = 4'hF;
        wready = 1'b0;
        grants = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (ch_wready != 4'b0000) grants++;
            if (i > 0) begin
                chk($sformatf("bp%0d_wvalid", i), 32'(wvalid), 1);
                chk($sformatf("bp%0d_wdata", i), 32'(wdata), 32'h0B0);
            end
            cyc();
        end
        chk("bp_grants", 32'(grants), 1);
        wready = 1'b1;
        q.delete();
        for (int i = 0; i < 6; i++) begin
            #1;
            if (wvalid) q.push_back(wdata);
            cyc();
        end
        ch_wvalid = '0;
        bp_exp = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB0, 8'hB1};
        chk("bp_count", 32'(q.size()), 6);
        for (int i = 0; i < 6 && i < q.size(); i++)
            chk($sformatf("bp_out%0d", i), 32'(q[i]), 32'(bp_exp[i]));

        // Echo loop with clients requesting
        reset_dut();
        echo = 1'b1;
        ch_wdata = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
        ch_wvalid = 4'hF;
        ch_rready = 4'hF;
        wready = 1'b1;
        q.delete();
        for (int i = 0; i < 8; i++) begin
            rvalid = (i < 3);
            rdata = 8'(8'h31 + i);
            #1;
            chk($sformatf("ec%0d_ch_wready", i), 32'(ch_wready), 0);
            chk($sformatf("ec%0d_ch_rvalid", i), 32'(ch_rvalid), 0);
            if (i < 3) chk($sformatf("ec%0d_rready", i), 32'(rready), 1);
            if (wvalid) q.push_back(wdata);
            cyc();
        end
        rvalid = 1'b0;
        echo = 1'b0;
        ch_wvalid = '0;
        ec_exp = '{8'h31, 8'h32, 8'h33};
        chk("ec_count", 32'(q.size()), 3);
        for (int i = 0; i < 3 && i < q.size(); i++)
            chk($sformatf("ec_out%0d", i), 32'(q[i]), 32'(ec_exp[i]));

`ifdef TX_LINE_LOCK_EN
        begin
            logic [7:0] line[3];
            int idx;
            line = '{8'h48, 8'h49, 8'h0A};
            idx = 0;
            reset_dut();
            ch_wdata = {8'hD3, 8'hD2, 8'h00, 8'hD0};
            wready = 1'b1;
            q.delete();
            for (int i = 0; i < 6; i++) begin
                ch_wdata[15:8] = (idx < 3) ? line[idx] : 8'h00;
                ch_wvalid = {2'b01, (idx < 3), 1'b0};
                #1;
                if (ch_wready != 4'b0000) q.push_back({4'h0, ch_wready});
                if (ch_wready[1]) idx++;
                cyc();
            end
            ch_wvalid = '0;
            chk("lk_g0", (q.size() > 0) ? 32'(q[0]) : 32'hFFFF, 32'h2);
            chk("lk_g1", (q.size() > 1) ? 32'(q[1]) : 32'hFFFF, 32'h2);
            chk("lk_g2", (q.size() > 2) ? 32'(q[2]) : 32'hFFFF, 32'h2);
            chk("lk_g3", (q.size() > 3) ? 32'(q[3]) : 32'hFFFF, 32'h4);
        end
`endif

        // Reset mid-stream with both holds full and sel=2
        reset_dut();
        ch_rready = 4'hF;
        rvalid = 1'b1;
        rdata = 8'h1B; cyc();
        rdata = 8'h02; cyc();
        rdata = 8'h77;
        ch_rready = 4'h0;
        ch_wdata = {8'hE3, 8'hE2, 8'hE1, 8'hE0};
        ch_wvalid = 4'b0001;
        wready = 1'b0;
        cyc();
        rvalid = 1'b0;
        #1;
        chk("pre_ch_rvalid", 32'(ch_rvalid), 32'h4);
        chk("pre_wvalid", 32'(wvalid), 1);
        chk("pre_sel", 32'(sel), 2);
        rst = 1'b0;
        #1;
        chk("mid_wvalid", 32'(wvalid), 0);
        chk("mid_sel", 32'(sel), 0);
        chk("mid_ch_rvalid", 32'(ch_rvalid), 0);
        chk("mid_rready", 32'(rready), 0);
        chk("mid_ch_wready", 32'(ch_wready), 0);
        ch_wvalid = '0;
        cyc();
        cyc();
        rst = 1'b1;
        ch_rready = 4'hF;
        rvalid = 1'b1;
        rdata = 8'h41;
        #1;
        chk("post_rready", 32'(rready), 1);
        chk("post_ch_rvalid0", 32'(ch_rvalid), 0);
        cyc();
        rvalid = 1'b0;
        #1;
        chk("post_ch_rvalid1", 32'(ch_rvalid), 32'h1);
        chk("post_ch_rdata", 32'(ch_rdata[7:0]), 32'h41);
        chk("post_wvalid", 32'(wvalid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
